iir_sos_seq: RTL and testbench

- Control/sequencing stage sitting directly upstream of a cascade of N_SEC second-order IIR sections.
- Loads each section's four coefficients from an external coefficient ROM.
- Per input sample, registers the sample and drives the shared ce/mult_sel accumulate window that every section consumes.
- Registers the last section's output with a valid strobe for downstream consumers.

---
 rtl/iir_sos_seq_pkg.sv | 31 +++
 rtl/iir_coef_loader.sv | 106 ++++++++++
 rtl/iir_sos_seq.sv | 171 +++++++++++++++++
 tb/tb_iir_sos_seq.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_sos_seq_pkg.sv
// Shared types and constants for the IIR second-order-section sequencer.
//   - seq_state_e : sequencer FSM states
//   - IDX_*       : coefficient index within a section's register file
//   - *_DEF       : default format/size of the cascade
//   - SAMP_W/COEFF_W : total sample/coefficient widths for the default format
package iir_sos_seq_pkg;

    localparam int unsigned N_SEC_DEF    = 4;
    localparam int unsigned SAMP_WH_DEF  = 4;
    localparam int unsigned SAMP_FR_DEF  = 23;
    localparam int unsigned COEFF_WH_DEF = 2;
    localparam int unsigned COEFF_FR_DEF = 14;

    localparam int unsigned SAMP_W  = SAMP_WH_DEF + SAMP_FR_DEF;
    localparam int unsigned COEFF_W = COEFF_WH_DEF + COEFF_FR_DEF;

    localparam logic [1:0] IDX_A1 = 2'd0;
    localparam logic [1:0] IDX_A2 = 2'd1;
    localparam logic [1:0] IDX_B  = 2'd2;
    localparam logic [1:0] IDX_K  = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StPre,
        StCe0,
        StCe1,
        StEnd
    } seq_state_e;

endpackage

// File: rtl/iir_coef_loader.sv
// Coefficient loader: walks the coefficient ROM from address 0 to 4*N_SEC-1 (one read per
// cycle) and, one cycle after each read, writes the returned word into the addressed
// section's register file.
// Ports:
//   clk, nrst        clock, asynchronous active-low reset
//   start            pulse: begin a full load (clears done)
//   busy             load in progress (first read through last write)
//   done             all coefficients written; sticky until reset or start
//   last_wr          high in the cycle of the final coefficient write
//   rom_rd/rom_addr  ROM read strobe and address
//   rom_data         ROM read data, valid one cycle after rom_rd
//   sec_we           one-hot write enable, section = addr >> 2
//   c_addr/c_in      coefficient index and data shared by all sections
module iir_coef_loader
    import iir_sos_seq_pkg::*;
#(
    parameter int unsigned N_SEC   = N_SEC_DEF,
    parameter int unsigned COEF_W  = COEFF_W,
    parameter int unsigned ROM_AW  = $clog2(4 * N_SEC)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              last_wr,
    output logic              rom_rd,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [COEF_W-1:0] rom_data,
    output logic [N_SEC-1:0]  sec_we,
    output logic [1:0]        c_addr,
    output logic [COEF_W-1:0] c_in
);

    localparam int unsigned N_COEF = 4 * N_SEC;
    // One extra bit so the counter can reach N_COEF and stop issuing reads.
    localparam int unsigned CNT_W  = ROM_AW + 1;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [ROM_AW-1:0] wr_addr_q, wr_addr_d;

    always_comb begin
        rom_rd  = busy_q && (cnt_q < CNT_W'(N_COEF));
        last_wr = wr_q && (wr_addr_q[1:0] == IDX_K)
                  && ((wr_addr_q >> 2) == ROM_AW'(N_SEC - 1));
    end

    always_comb begin
        busy_d    = busy_q;
        done_d    = done_q;
        cnt_d     = cnt_q;
        wr_d      = 1'b0;
        wr_addr_d = wr_addr_q;
        if (start) begin
            busy_d = 1'b1;
            done_d = 1'b0;
            cnt_d  = '0;
        end else begin
            // Read pipeline: the word for address cnt_q arrives next cycle.
            wr_d = rom_rd;
            if (rom_rd) begin
                wr_addr_d = cnt_q[ROM_AW-1:0];
                cnt_d     = cnt_q + CNT_W'(1);
            end
            if (last_wr) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            busy_q    <= busy_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    always_comb begin
        sec_we = '0;
        for (int s = 0; s < N_SEC; s++) begin
            if (wr_q && ((wr_addr_q >> 2) == ROM_AW'(s))) begin
                sec_we[s] = 1'b1;
            end
        end
    end

    assign rom_addr = rom_rd ? cnt_q[ROM_AW-1:0] : '0;
    assign c_addr   = wr_q ? wr_addr_q[1:0] : 2'd0;
    assign c_in     = wr_q ? rom_data : '0;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: rtl/iir_sos_seq.sv
// Sequencer for a cascade of N_SEC second-order IIR sections.
// Loads all section coefficients from an external ROM on cfg_start, then per accepted
// sample runs the shared PRE -> CE0 -> CE1 -> END window (ce for two cycles, mult_sel in
// CE0 only) and registers the last section's output with a one-cycle out_valid strobe.
// Ports:
//   clk, nrst                      clock, asynchronous active-low reset
//   cfg_start/cfg_busy/cfg_done    coefficient load control and status
//   rom_rd/rom_addr/rom_data       coefficient ROM interface (1-cycle read latency)
//   sec_we/c_addr/c_in             coefficient write port to the sections
//   samp_valid/samp_ready/samp_in  input sample handshake
//   sec_din                        registered sample to section 0
//   ce/mult_sel                    shared section compute window
//   last_dout                      last section output
//   out_valid/dout                 registered output and strobe
//   ovr                            sticky sample-dropped flag
module iir_sos_seq
    import iir_sos_seq_pkg::*;
#(
    parameter int unsigned N_SEC    = N_SEC_DEF,
    parameter int unsigned SAMP_WH  = SAMP_WH_DEF,
    parameter int unsigned SAMP_FR  = SAMP_FR_DEF,
    parameter int unsigned COEFF_WH = COEFF_WH_DEF,
    parameter int unsigned COEFF_FR = COEFF_FR_DEF,
    parameter int unsigned ROM_AW   = $clog2(4 * N_SEC)
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         cfg_start,
    output logic                         cfg_busy,
    output logic                         cfg_done,
    output logic                         rom_rd,
    output logic [ROM_AW-1:0]            rom_addr,
    input  logic [COEFF_WH+COEFF_FR-1:0] rom_data,
    output logic [N_SEC-1:0]             sec_we,
    output logic [1:0]                   c_addr,
    output logic [COEFF_WH+COEFF_FR-1:0] c_in,
    input  logic                         samp_valid,
    output logic                         samp_ready,
    input  logic [SAMP_WH+SAMP_FR-1:0]   samp_in,
    output logic [SAMP_WH+SAMP_FR-1:0]   sec_din,
    output logic                         ce,
    output logic                         mult_sel,
    input  logic [SAMP_WH+SAMP_FR-1:0]   last_dout,
    output logic                         out_valid,
    output logic [SAMP_WH+SAMP_FR-1:0]   dout,
    output logic                         ovr
);

    localparam int unsigned SW = SAMP_WH + SAMP_FR;
    localparam int unsigned KW = COEFF_WH + COEFF_FR;

    seq_state_e    state_q, state_d;
    logic          pending_q, pending_d;
    logic          ovr_q, ovr_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] din_q, din_d;
    logic [SW-1:0] dout_q, dout_d;

    logic load_start;
    logic load_last;
    logic accept;

    iir_coef_loader #(
        .N_SEC  (N_SEC),
        .COEF_W (KW),
        .ROM_AW (ROM_AW)
    ) u_loader (
        .clk      (clk),
        .nrst     (nrst),
        .start    (load_start),
        .busy     (cfg_busy),
        .done     (cfg_done),
        .last_wr  (load_last),
        .rom_rd   (rom_rd),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .sec_we   (sec_we),
        .c_addr   (c_addr),
        .c_in     (c_in)
    );

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        ovr_d       = ovr_q;
        out_valid_d = 1'b0;
        load_start  = 1'b0;
        accept      = 1'b0;
        ce          = 1'b0;
        mult_sel    = 1'b0;
        samp_ready  = (state_q == StIdle) && cfg_done && !pending_q;

        unique case (state_q)
            StIdle: begin
                // A (deferred) load takes priority over a sample in the same cycle.
                if (cfg_start || pending_q) begin
                    load_start = 1'b1;
                    pending_d  = 1'b0;
                    state_d    = StLoad;
                end else if (samp_valid && samp_ready) begin
                    accept  = 1'b1;
                    state_d = StPre;
                end
            end
            StLoad: begin
                if (load_last) begin
                    state_d = StIdle;
                end
            end
            StPre: begin
                state_d = StCe0;
            end
            StCe0: begin
                ce       = 1'b1;
                mult_sel = 1'b1;
                state_d  = StCe1;
            end
            StCe1: begin
                ce      = 1'b1;
                state_d = StEnd;
            end
            StEnd: begin
                out_valid_d = 1'b1;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A start during a sample window is remembered and serviced back in idle.
        if (cfg_start && (state_q != StIdle) && (state_q != StLoad)) begin
            pending_d = 1'b1;
        end

        // Start (when acted upon) clears the overrun flag; a same-cycle drop wins.
        if (cfg_start && (state_q != StLoad)) begin
            ovr_d = 1'b0;
        end
        if (samp_valid && !accept) begin
            ovr_d = 1'b1;
        end

        din_d  = accept ? samp_in : din_q;
        dout_d = out_valid_d ? last_dout : dout_q;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= StIdle;
            pending_q   <= 1'b0;
            ovr_q       <= 1'b0;
            out_valid_q <= 1'b0;
            din_q       <= '0;
            dout_q      <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            ovr_q       <= ovr_d;
            out_valid_q <= out_valid_d;
            din_q       <= din_d;
            dout_q      <= dout_d;
        end
    end

    assign sec_din   = din_q;
    assign dout      = dout_q;
    assign out_valid = out_valid_q;
    assign ovr       = ovr_q;

endmodule

// File: tb/tb_iir_sos_seq.sv
// Self-checking bench for iir_sos_seq: coefficient load, single-sample window table,
// randomized sample stream against a timing-rule model, deferred reload, reset mid-window.
module tb_iir_sos_seq;

    localparam int unsigned N_SEC = 4;
    localparam int unsigned SW    = 27;
    localparam int unsigned KW    = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned NCOEF = 4 * N_SEC;

    logic              clk;
    logic              nrst;
    logic              cfg_start;
    logic              cfg_busy;
    logic              cfg_done;
    logic              rom_rd;
    logic [AW-1:0]     rom_addr;
    logic [KW-1:0]     rom_data;
    logic [N_SEC-1:0]  sec_we;
    logic [1:0]        c_addr;
    logic [KW-1:0]     c_in;
    logic              samp_valid;
    logic              samp_ready;
    logic [SW-1:0]     samp_in;
    logic [SW-1:0]     sec_din;
    logic              ce;
    logic              mult_sel;
    logic [SW-1:0]     last_dout;
    logic              out_valid;
    logic [SW-1:0]     dout;
    logic              ovr;

    iir_sos_seq #(
        .N_SEC    (N_SEC),
        .SAMP_WH  (4),
        .SAMP_FR  (23),
        .COEFF_WH (2),
        .COEFF_FR (14)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .cfg_start  (cfg_start),
        .cfg_busy   (cfg_busy),
        .cfg_done   (cfg_done),
        .rom_rd     (rom_rd),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .sec_we     (sec_we),
        .c_addr     (c_addr),
        .c_in       (c_in),
        .samp_valid (samp_valid),
        .samp_ready (samp_ready),
        .samp_in    (samp_in),
        .sec_din    (sec_din),
        .ce         (ce),
        .mult_sel   (mult_sel),
        .last_dout  (last_dout),
        .out_valid  (out_valid),
        .dout       (dout),
        .ovr        (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Coefficient ROM with one-cycle read latency.
    logic [KW-1:0] rom [NCOEF];
    initial rom_data = '0;
    always @(posedge clk) begin
        if (rom_rd) rom_data <= rom[rom_addr];
    end

    int nvec = 0;
    int nbad = 0;

    // Section register files as seen on the coefficient write port.
    logic [KW-1:0] coef [N_SEC][4];
    int busy_n;
    int hit_n;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_load();
        @(negedge clk);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    // Watch the write port until cfg_busy has risen and fallen (bounded).
    task automatic collect_load();
        bit seen = 1'b0;
        busy_n = 0;
        hit_n  = 0;
        for (int s = 0; s < N_SEC; s++)
            for (int k = 0; k < 4; k++) coef[s][k] = '0;
        for (int i = 0; i < 200; i++) begin
            if (cfg_busy) begin
                seen = 1'b1;
                busy_n++;
            end else if (seen) begin
                break;
            end
            for (int s = 0; s < N_SEC; s++) begin
                if (sec_we[s]) begin
                    coef[s][c_addr] = c_in;
                    if (s == 2 && c_addr == 2'd3 && c_in == 16'd12) hit_n++;
                end
            end
            @(negedge clk);
        end
        chk("load_terminated", 64'(seen && !cfg_busy), 64'(1));
    endtask

    task automatic chk_coefs();
        for (int s = 0; s < N_SEC; s++)
            for (int k = 0; k < 4; k++)
                chk($sformatf("coef_s%0d_k%0d", s, k), 64'(coef[s][k]), 64'(rom[4*s+k]));
    endtask

    typedef struct {
        logic valid;
        logic rdy;
        logic ce;
        logic ms;
        logic ov;
    } row_t;

    row_t tbl [7];

    initial begin
        int last_acc;
        int next_ok;
        int d;
        logic [SW-1:0] exp_din;
        logic [SW-1:0] exp_dout;
        logic [SW-1:0] ld_cur;
        logic          exp_ovr;
        logic          v;
        logic [SW-1:0] s_val;

        // Per-cycle expectations for one sample accepted at offset 0.
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        nrst       = 1'b0;
        cfg_start  = 1'b0;
        samp_valid = 1'b0;
        samp_in    = '0;
        last_dout  = '0;
        for (int i = 0; i < NCOEF; i++) rom[i] = 16'(i + 1);

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(cfg_busy), 64'(0));
        chk("rst_done", 64'(cfg_done), 64'(0));
        chk("rst_rom_rd", 64'(rom_rd), 64'(0));
        chk("rst_sec_we", 64'(sec_we), 64'(0));
        chk("rst_ce", 64'(ce), 64'(0));
        chk("rst_mult_sel", 64'(mult_sel), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_dout", 64'(dout), 64'(0));
        chk("rst_ovr", 64'(ovr), 64'(0));
        chk("rst_ready", 64'(samp_ready), 64'(0));
        nrst = 1'b1;
        @(negedge clk);

        // Sample before any load is dropped.
        samp_valid = 1'b1;
        samp_in    = 27'h0111111;
        @(negedge clk);
        samp_valid = 1'b0;
        chk("preload_ovr", 64'(ovr), 64'(1));
        chk("preload_ready", 64'(samp_ready), 64'(0));

        // Load with ROM[i] = i + 1.
        start_load();
        collect_load();
        chk("load_busy_cycles", 64'(busy_n), 64'(NCOEF + 1));
        chk("load_s2_k3_hits", 64'(hit_n), 64'(1));
        chk_coefs();
        chk("load_done", 64'(cfg_done), 64'(1));
        chk("load_ovr_cleared", 64'(ovr), 64'(0));
        chk("load_ready", 64'(samp_ready), 64'(1));

        // Single sample window from the table.
        last_dout = 27'h1234567;
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("tbl%0d_ready", i), 64'(samp_ready), 64'(tbl[i].rdy));
            chk($sformatf("tbl%0d_ce", i), 64'(ce), 64'(tbl[i].ce));
            chk($sformatf("tbl%0d_mult_sel", i), 64'(mult_sel), 64'(tbl[i].ms));
            chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].ov));
            if (i == 1) chk("tbl_sec_din", 64'(sec_din), 64'(27'h0400000));
            if (i == 5) chk("tbl_dout", 64'(dout), 64'(27'h1234567));
            samp_valid = tbl[i].valid;
            samp_in    = 27'h0400000;
            @(negedge clk);
        end

        // Randomized stream, with a stretch of samp_valid held every cycle.
        last_acc = -100;
        next_ok  = 0;
        exp_din  = 27'h0400000;
        exp_dout = 27'h1234567;
        ld_cur   = 27'h1234567;
        exp_ovr  = 1'b0;
        for (int c = 0; c < 400; c++) begin
            d = c - last_acc;
            if (d == 5) exp_dout = ld_cur;
            chk("rnd_ready", 64'(samp_ready), 64'(c >= next_ok));
            chk("rnd_ce", 64'(ce), 64'(d == 2 || d == 3));
            chk("rnd_mult_sel", 64'(mult_sel), 64'(d == 2));
            chk("rnd_out_valid", 64'(out_valid), 64'(d == 5));
            chk("rnd_dout", 64'(dout), 64'(exp_dout));
            chk("rnd_sec_din", 64'(sec_din), 64'(exp_din));
            chk("rnd_ovr", 64'(ovr), 64'(exp_ovr));
            v      = (c >= 200 && c < 260) ? 1'b1 : ($urandom_range(0, 3) == 0);
            s_val  = SW'($urandom);
            ld_cur = SW'($urandom);
            samp_valid = v;
            samp_in    = s_val;
            last_dout  = ld_cur;
            if (v) begin
                if (c >= next_ok) begin
                    last_acc = c;
                    next_ok  = c + 5;
                    exp_din  = s_val;
                end else begin
                    exp_ovr = 1'b1;
                end
            end
            @(negedge clk);
        end
        samp_valid = 1'b0;
        repeat (6) @(negedge clk);

        // cfg_start during CE0: window completes, reload deferred to idle.
        for (int i = 0; i < NCOEF; i++) rom[i] = 16'($urandom_range(1, 16'hFFFE));
        last_dout = 27'h2AAAAAA;
        chk("defer_ready_t", 64'(samp_ready), 64'(1));
        samp_valid = 1'b1;
        samp_in    = 27'h0400000;
        @(negedge clk);
        samp_valid = 1'b0;
        @(negedge clk);
        chk("defer_ce0_ce", 64'(ce), 64'(1));
        chk("defer_ce0_mult_sel", 64'(mult_sel), 64'(1));
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        chk("defer_ce1_busy", 64'(cfg_busy), 64'(0));
        @(negedge clk);
        @(negedge clk);
        chk("defer_t5_out_valid", 64'(out_valid), 64'(1));
        chk("defer_t5_dout", 64'(dout), 64'(27'h2AAAAAA));
        chk("defer_t5_ready", 64'(samp_ready), 64'(0));
        chk("defer_t5_busy", 64'(cfg_busy), 64'(0));
        @(negedge clk);
        chk("defer_t6_busy", 64'(cfg_busy), 64'(1));
        chk("defer_t6_done", 64'(cfg_done), 64'(0));
        chk("defer_t6_ready", 64'(samp_ready), 64'(0));
        collect_load();
        chk("defer_busy_cycles", 64'(busy_n), 64'(NCOEF + 1));
        chk_coefs();
        chk("defer_done", 64'(cfg_done), 64'(1));
        chk("defer_ready", 64'(samp_ready), 64'(1));
        chk("defer_ovr_cleared", 64'(ovr), 64'(0));

        // Reset during CE1 kills the window and the loaded state.
        last_dout  = 27'h0ABCDEF;
        samp_valid = 1'b1;
        samp_in    = 27'h0123456;
        @(negedge clk);
        samp_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstw_ce1_ce", 64'(ce), 64'(1));
        nrst = 1'b0;
        #1;
        chk("rstw_ce", 64'(ce), 64'(0));
        chk("rstw_done", 64'(cfg_done), 64'(0));
        chk("rstw_dout", 64'(dout), 64'(0));
        chk("rstw_out_valid", 64'(out_valid), 64'(0));
        chk("rstw_sec_din", 64'(sec_din), 64'(0));
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        samp_valid = 1'b1;
        @(negedge clk);
        samp_valid = 1'b0;
        chk("rstw_drop_ovr", 64'(ovr), 64'(1));
        chk("rstw_drop_ready", 64'(samp_ready), 64'(0));
        repeat (6) @(negedge clk);
        chk("rstw_no_output", 64'(out_valid), 64'(0));
        chk("rstw_no_ce", 64'(ce), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
